// File: rtl/uart_tx_controller.sv
// uart_tx_controller: frame sequencer for an 8N1 UART transmitter.
// Drives LOAD/SHIFT strobes to an external shift register and builds the serial line from
// its LSB. Optional parity bit is built when the macro UART_TX_PARITY_EN is defined.
module uart_tx_controller #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA_VALID,
    input  logic [7:0] DATA_IN,
    input  logic       SER_DATA,
    output logic       LOAD,
    output logic       SHIFT,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            bit_end;

`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`else
    // DATA_IN and PARITY_ODD only feed the parity logic, which is not built here.
    logic            unused_cfg;
    assign unused_cfg = ^{DATA_IN, 1'(PARITY_ODD)};
`endif

    assign bit_end = (cnt_q == CntLast);

    // Next-state, baud counter and bit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (LOAD) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^DATA_IN) ^ 1'(PARITY_ODD);
`endif
                end
            end
            StStart: begin
                cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
                // DATA_VALID in this cycle is not looked at; the next accept is from IDLE.
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Strobes and status; LOAD is gated by RST so it stays low throughout reset.
    always_comb begin
        LOAD  = RST && (state_q == StIdle) && DATA_VALID;
        SHIFT = (state_q == StData) && bit_end;
        DONE  = (state_q == StStop) && bit_end;
        BUSY  = (state_q != StIdle);
    end

    // Serial line decoded from registers and the shift-register LSB only.
    always_comb begin
        TX_OUT = 1'b1;
        case (state_q)
            StIdle:   TX_OUT = 1'b1;
            StStart:  TX_OUT = 1'b0;
            StData:   TX_OUT = SER_DATA;
`ifdef UART_TX_PARITY_EN
            StParity: TX_OUT = parity_q;
`endif
            StStop:   TX_OUT = 1'b1;
            default:  TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: three instances (4 clk/bit even, 2 clk/bit,
// 4 clk/bit odd parity) each paired with a behavioural shift register.
module tb_uart_tx_controller;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] dv;
    logic [7:0] din [3];
    logic [2:0] ser, load, shift, tx, busy, done;
    logic [7:0] sr [3];
    logic [2:0] pre_load;

    logic [2:0] lg_tx    [256];
    logic [2:0] lg_load  [256];
    logic [2:0] lg_shift [256];
    logic [2:0] lg_busy  [256];
    logic [2:0] lg_done  [256];

    int n_checks;
    int n_fail;

    uart_tx_controller #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_a (
        .CLK(clk), .RST(rst_n), .DATA_VALID(dv[0]), .DATA_IN(din[0]), .SER_DATA(ser[0]),
        .LOAD(load[0]), .SHIFT(shift[0]), .TX_OUT(tx[0]), .BUSY(busy[0]), .DONE(done[0])
    );
    uart_tx_controller #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) u_b (
        .CLK(clk), .RST(rst_n), .DATA_VALID(dv[1]), .DATA_IN(din[1]), .SER_DATA(ser[1]),
        .LOAD(load[1]), .SHIFT(shift[1]), .TX_OUT(tx[1]), .BUSY(busy[1]), .DONE(done[1])
    );
    uart_tx_controller #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_c (
        .CLK(clk), .RST(rst_n), .DATA_VALID(dv[2]), .DATA_IN(din[2]), .SER_DATA(ser[2]),
        .LOAD(load[2]), .SHIFT(shift[2]), .TX_OUT(tx[2]), .BUSY(busy[2]), .DONE(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural right-shift registers fed by the DUT strobes.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (load[i]) sr[i] <= din[i];
            else if (shift[i]) sr[i] <= sr[i] >> 1;
        end
    end
    assign ser = {sr[2][0], sr[1][0], sr[0][0]};

    // Expected {tx, shift, done, busy} k cycles after the accepting edge.
    function automatic logic [3:0] exp_vec(input logic [7:0] data, input bit odd,
                                           input int cpb, input int k);
        int   b;
        int   ph;
        logic t, s, d, bz;
        b  = k / cpb;
        ph = k % cpb;
        bz = (k < NBITS * cpb);
        d  = (k == NBITS * cpb - 1);
        s  = (b >= 1) && (b <= 8) && (ph == cpb - 1);
        if (!bz) t = 1'b1;
        else if (b == 0) t = 1'b0;
        else if (b <= 8) t = data[b-1];
        else if (NBITS == 11 && b == 9) t = (^data) ^ odd;
        else t = 1'b1;
        return {t, s, d, bz};
    endfunction

    // Request a frame on instance sel; returns one step after the accepting edge.
    task automatic launch(input int sel, input logic [7:0] data);
        @(posedge clk); #1;
        din[sel] = data;
        dv[sel]  = 1'b1;
        @(negedge clk);
        pre_load = load;
        @(posedge clk); #1;
    endtask

    // Record n cycles of outputs; pulse[k] drives DATA_VALID of instance sel in cycle k.
    task automatic capture(input int n, input int sel, input logic [255:0] pulse);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            dv[sel] = pulse[k];
            @(negedge clk);
            lg_tx[k] = tx; lg_load[k] = load; lg_shift[k] = shift;
            lg_busy[k] = busy; lg_done[k] = done;
        end
        dv[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dv    = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 8'hA5;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({tx, busy, done, load, shift} !== {3'b111, 12'h000}) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected %b", {tx, busy, done, load, shift},
                     {3'b111, 12'h000});
        end
        dv = 3'b000;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [3:0] got, exp;
        int n_sh, n_dn, n_bz, n_ld;
        launch(0, 8'hA5);
        n_checks++;
        if (pre_load !== 3'b001) begin
            n_fail++; $display("FAIL basic_load got %b expected 001", pre_load);
        end
        capture(NBITS * 4 + 4, 0, '0);
        n_sh = 0; n_dn = 0; n_bz = 0; n_ld = 0;
        for (int k = 0; k < NBITS * 4 + 4; k++) begin
            exp = exp_vec(8'hA5, 1'b0, 4, k);
            got = {lg_tx[k][0], lg_shift[k][0], lg_done[k][0], lg_busy[k][0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic k=%0d {tx,shift,done,busy} got %b expected %b", k, got, exp);
            end
            n_sh += int'(lg_shift[k][0]); n_dn += int'(lg_done[k][0]);
            n_bz += int'(lg_busy[k][0]); n_ld += int'(lg_load[k][0]);
        end
        n_checks++;
        if (n_sh != 8 || n_dn != 1 || n_bz != NBITS * 4 || n_ld != 0) begin
            n_fail++;
            $display("FAIL basic_counts shift=%0d done=%0d busy=%0d load=%0d expected 8 1 %0d 0",
                     n_sh, n_dn, n_bz, n_ld, NBITS * 4);
        end
    endtask

    task automatic test_parity;
        logic [3:0] got, exp;
        launch(0, 8'h07);
        capture(NBITS * 4 + 2, 0, '0);
        for (int k = 0; k < NBITS * 4 + 2; k++) begin
            exp = exp_vec(8'h07, 1'b0, 4, k);
            got = {lg_tx[k][0], lg_shift[k][0], lg_done[k][0], lg_busy[k][0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL parity_even k=%0d got %b expected %b", k, got, exp);
            end
        end
        launch(2, 8'h07);
        capture(NBITS * 4 + 2, 2, '0);
        for (int k = 0; k < NBITS * 4 + 2; k++) begin
            exp = exp_vec(8'h07, 1'b1, 4, k);
            got = {lg_tx[k][2], lg_shift[k][2], lg_done[k][2], lg_busy[k][2]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL parity_odd k=%0d got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [3:0]   got, exp;
        logic [255:0] pulse;
        pulse = '0;
        pulse[4] = 1'b1;
        pulse[38] = 1'b1;
        pulse[NBITS * 4 - 1] = 1'b1;
        launch(0, 8'hA5);
        capture(NBITS * 4 + 4, 0, pulse);
        for (int k = 0; k < NBITS * 4 + 4; k++) begin
            exp = exp_vec(8'hA5, 1'b0, 4, k);
            got = {lg_tx[k][0], lg_shift[k][0], lg_done[k][0], lg_busy[k][0]};
            n_checks++;
            if (got !== exp || lg_load[k][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore k=%0d got %b load %b expected %b load 0", k, got,
                         lg_load[k][0], exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int L;
        int n_ld;
        L = NBITS * 4 + 1;
        n_ld = 0;
        @(posedge clk); #1;
        din[0] = 8'h00;
        dv[0]  = 1'b1;
        for (int j = 0; j < 3 * L; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            lg_tx[j] = tx; lg_load[j] = load; lg_busy[j] = busy; lg_done[j] = done;
        end
        dv[0] = 1'b0;
        for (int j = 0; j < 3 * L; j++) begin
            n_ld += int'(lg_load[j][0]);
            n_checks++;
            if (lg_load[j][0] !== (j % L == 0) || lg_busy[j][0] !== (j % L != 0)) begin
                n_fail++;
                $display("FAIL b2b j=%0d load %b busy %b expected load %b busy %b", j,
                         lg_load[j][0], lg_busy[j][0], (j % L == 0), (j % L != 0));
            end
        end
        n_checks++;
        if (n_ld != 3) begin
            n_fail++; $display("FAIL b2b_loads got %0d expected 3", n_ld);
        end
        n_checks++;
        if ({lg_done[L-1][0], lg_tx[L-1][0], lg_tx[L][0], lg_tx[L+1][0]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL b2b_gap {done,stop,idle,start} got %b expected 1110",
                     {lg_done[L-1][0], lg_tx[L-1][0], lg_tx[L][0], lg_tx[L+1][0]});
        end
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        logic [3:0] got, exp;
        launch(0, 8'h00);
        capture(18, 0, '0);
        n_checks++;
        if ({lg_tx[17][0], lg_busy[17][0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_pre {tx,busy} got %b expected 01",
                     {lg_tx[17][0], lg_busy[17][0]});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx[0], busy[0], done[0], shift[0], load[0]} !== 5'b10000) begin
            n_fail++;
            $display("FAIL abort_async {tx,busy,done,shift,load} got %b expected 10000",
                     {tx[0], busy[0], done[0], shift[0], load[0]});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx[0], busy[0], done[0]} !== 3'b100) begin
                n_fail++;
                $display("FAIL abort_hold {tx,busy,done} got %b expected 100",
                         {tx[0], busy[0], done[0]});
            end
        end
        #2 rst_n = 1'b1;
        launch(0, 8'h3C);
        n_checks++;
        if (pre_load[0] !== 1'b1) begin
            n_fail++; $display("FAIL abort_first_load got %b expected 1", pre_load[0]);
        end
        capture(NBITS * 4 + 2, 0, '0);
        for (int k = 0; k < NBITS * 4 + 2; k++) begin
            exp = exp_vec(8'h3C, 1'b0, 4, k);
            got = {lg_tx[k][0], lg_shift[k][0], lg_done[k][0], lg_busy[k][0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_refr k=%0d got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_fast;
        logic [3:0] got, exp;
        launch(1, 8'hFF);
        capture(NBITS * 2 + 2, 1, '0);
        for (int k = 0; k < NBITS * 2 + 2; k++) begin
            exp = exp_vec(8'hFF, 1'b0, 2, k);
            got = {lg_tx[k][1], lg_shift[k][1], lg_done[k][1], lg_busy[k][1]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fast k=%0d got %b expected %b", k, got, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
